// File: rtl/smc_regif_lite.sv
// AHB-lite front end for the SMC lite config register: registered select, read mux, ERROR on writes.
// Optional feature macro SMC_REGIF_WR_ERR_EN: when defined, writes get a two-cycle ERROR response.
module smc_regif_lite #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] CFG_OFFSET = 8'h00
) (
  input  logic              hclk,
  input  logic              sys_reset,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hready_in,
  input  logic [31:0]       cfg_rdata,
  output logic              selreg,
  output logic [31:0]       hrdata,
  output logic              hready_out,
  output logic [1:0]        hresp
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1
`ifdef SMC_REGIF_WR_ERR_EN
    ,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
`endif
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_selreg;
  logic   w_selreg_next;
  logic   w_acc;
  logic   w_hit;
  logic   w_unused;

  assign w_acc    = hsel & htrans[1] & hready_in;
  assign w_hit    = (haddr[ADDR_W-1:2] == CFG_OFFSET[ADDR_W-1:2]);
  assign w_unused = &{1'b0, haddr[1:0], htrans[0]};

  always_ff @(posedge hclk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state  <= S_IDLE;
      r_selreg <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_selreg <= w_selreg_next;
    end
  end

  // IDLE, RD and ERR2 all accept a new address phase the same way.
  always_comb begin
    w_state_next = S_IDLE;
    case (r_state)
`ifdef SMC_REGIF_WR_ERR_EN
      S_ERR1: w_state_next = S_ERR2;
`endif
      default: begin
        if (w_acc && !hwrite) begin
          w_state_next = S_RD;
`ifdef SMC_REGIF_WR_ERR_EN
        end else if (w_acc && hwrite) begin
          w_state_next = S_ERR1;
`endif
        end else begin
          w_state_next = S_IDLE;
        end
      end
    endcase
    w_selreg_next = (w_state_next == S_RD) && w_hit;
  end

  always_comb begin
    hready_out = 1'b1;
    hresp      = RESP_OKAY;
    case (r_state)
`ifdef SMC_REGIF_WR_ERR_EN
      S_ERR1: begin
        hready_out = 1'b0;
        hresp      = RESP_ERROR;
      end
      S_ERR2: begin
        hready_out = 1'b1;
        hresp      = RESP_ERROR;
      end
`endif
      default: begin
        hready_out = 1'b1;
        hresp      = RESP_OKAY;
      end
    endcase
  end

  assign selreg = r_selreg;
  assign hrdata = ((r_state == S_RD) && r_selreg) ? cfg_rdata : 32'h0;

endmodule

// File: tb/tb_smc_regif_lite.sv
// Directed bench for smc_regif_lite; follows SMC_REGIF_WR_ERR_EN for the write-response steps.
module tb_smc_regif_lite;

  logic        hclk = 1'b0;
  logic        sys_reset;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [7:0]  haddr;
  logic        hready_in;
  logic [31:0] cfg_rdata;
  logic        selreg;
  logic [31:0] hrdata;
  logic        hready_out;
  logic [1:0]  hresp;

  int checks = 0;
  int errors = 0;

  smc_regif_lite #(.ADDR_W(8), .CFG_OFFSET(8'h00)) dut (
    .hclk       (hclk),
    .sys_reset  (sys_reset),
    .hsel       (hsel),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .haddr      (haddr),
    .hready_in  (hready_in),
    .cfg_rdata  (cfg_rdata),
    .selreg     (selreg),
    .hrdata     (hrdata),
    .hready_out (hready_out),
    .hresp      (hresp)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic sel_e, input logic [31:0] rd_e,
                         input logic rdy_e, input logic [1:0] resp_e);
    chk({tag, ".selreg"}, {31'h0, selreg}, {31'h0, sel_e});
    chk({tag, ".hrdata"}, hrdata, rd_e);
    chk({tag, ".hready_out"}, {31'h0, hready_out}, {31'h0, rdy_e});
    chk({tag, ".hresp"}, {30'h0, hresp}, {30'h0, resp_e});
    $display("step %-12s sel=%b hrdata=%h hready_out=%b hresp=%b", tag, selreg, hrdata, hready_out, hresp);
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [7:0] addr, input logic rdy);
    hsel = sel; htrans = tr; hwrite = wr; haddr = addr; hready_in = rdy;
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    sys_reset = 1'b1;
    cfg_rdata = 32'hC000_0001;
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
    #2;
    chk_all("reset", 1'b0, 32'h0, 1'b1, 2'b00);
    @(negedge hclk);
    sys_reset = 1'b0;
    step();
    chk_all("idle", 1'b0, 32'h0, 1'b1, 2'b00);

    // single read at 0x00, then idle
    drive(1'b1, 2'b10, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("rd0", 1'b1, 32'hC000_0001, 1'b1, 2'b00);
    cfg_rdata = 32'h5A5A_A5A5;
    #1;
    chk("rd0_follow", hrdata, 32'h5A5A_A5A5);
    cfg_rdata = 32'hC000_0001;
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("rd0_idle", 1'b0, 32'h0, 1'b1, 2'b00);

    // back-to-back reads 0x00, 0x04 (unmapped), 0x00; byte offset bits ignored on the last
    drive(1'b1, 2'b10, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("b2b_0", 1'b1, 32'hC000_0001, 1'b1, 2'b00);
    drive(1'b1, 2'b11, 1'b0, 8'h04, 1'b1);
    step();
    chk_all("b2b_4", 1'b0, 32'h0, 1'b1, 2'b00);
    drive(1'b1, 2'b11, 1'b0, 8'h03, 1'b1);
    step();
    chk_all("b2b_0b", 1'b1, 32'hC000_0001, 1'b1, 2'b00);
    // BUSY transfer is not accepted
    drive(1'b1, 2'b01, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("busy", 1'b0, 32'h0, 1'b1, 2'b00);
    // hsel low is not accepted
    drive(1'b0, 2'b10, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("nosel", 1'b0, 32'h0, 1'b1, 2'b00);

    // write at 0x00
    drive(1'b1, 2'b10, 1'b1, 8'h00, 1'b1);
    step();
`ifdef SMC_REGIF_WR_ERR_EN
    chk_all("wr_err1", 1'b0, 32'h0, 1'b0, 2'b01);
    drive(1'b1, 2'b10, 1'b0, 8'h00, 1'b0);
    step();
    chk_all("wr_err2", 1'b0, 32'h0, 1'b1, 2'b01);
    drive(1'b1, 2'b10, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("rd_after_wr", 1'b1, 32'hC000_0001, 1'b1, 2'b00);
`else
    chk_all("wr_okay", 1'b0, 32'h0, 1'b1, 2'b00);
    drive(1'b1, 2'b10, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("rd_after_wr", 1'b1, 32'hC000_0001, 1'b1, 2'b00);
`endif
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("idle2", 1'b0, 32'h0, 1'b1, 2'b00);

    // asynchronous reset during a read data phase
    drive(1'b1, 2'b10, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("rst_pre", 1'b1, 32'hC000_0001, 1'b1, 2'b00);
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
    #1;
    sys_reset = 1'b1;
    #1;
    chk_all("rst_mid", 1'b0, 32'h0, 1'b1, 2'b00);
    @(negedge hclk);
    sys_reset = 1'b0;
    drive(1'b1, 2'b10, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("rst_post", 1'b1, 32'hC000_0001, 1'b1, 2'b00);
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("end_idle", 1'b0, 32'h0, 1'b1, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/smc_regif_lite.md
# smc_regif_lite

AHB-lite register access front end for the static memory controller's lite configuration register. It decodes the register address phase and drives a registered `selreg` into the downstream config register block. It returns that block's read data through the data phase and signals an ERROR response for writes to the read-only register. It sits between the SMC AHB slave port and the config register instance.

## Interface
Parameters:
- `ADDR_W`, 8: width of the register offset on `haddr`.
- `CFG_OFFSET`, 8'h00: word-aligned offset of the config register.

Ports:
- `hclk`  input  1  system clock; all state changes on the rising edge.
- `sys_reset`  input  1  asynchronous, active-high reset. One clock domain; reset is asynchronous and active-high.
- `hsel`  input  1  slave select from the AHB decoder.
- `htrans`  input  2  AHB transfer type; `htrans[1]`=1 means NONSEQ/SEQ.
- `hwrite`  input  1  1=write, 0=read.
- `haddr`  input  ADDR_W  byte offset; bits [1:0] are ignored.
- `hready_in`  input  1  bus-wide HREADY.
- `cfg_rdata`  input  32  read data from the config register block.
- `selreg`  output  1  registered select to the config register block.
- `hrdata`  output  32  AHB read data.
- `hready_out`  output  1  slave HREADY.
- `hresp`  output  2  AHB response: 2'b00=OKAY, 2'b01=ERROR.

## Operation
- Accepted transfer (`acc`) is `hsel & htrans[1] & hready_in`, sampled at a rising edge.
- `hit` is `haddr[ADDR_W-1:2] == CFG_OFFSET[ADDR_W-1:2]`.
- FSM states and transitions:
  - IDLE -> RD on `acc & !hwrite`.
  - IDLE -> ERR1 on `acc & hwrite` (with `SMC_REGIF_WR_ERR_EN`).
  - RD -> RD on `acc & !hwrite`.
  - RD -> ERR1 on `acc & hwrite`.
  - RD -> IDLE otherwise.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 follows the same exits as IDLE, so a transfer accepted in ERR2 is processed normally.
- `selreg` is registered. It is set on entering RD when `hit`=1 and cleared in every other case.
- Data output:
  - `hrdata` = `cfg_rdata` when state=RD and `selreg`=1.
  - `hrdata` = 32'h0 in every other case, including a read of an unmapped offset, which completes with OKAY.
- Responses:
  - RD: `hready_out`=1, `hresp`=OKAY.
  - ERR1: `hready_out`=0, `hresp`=ERROR.
  - ERR2: `hready_out`=1, `hresp`=ERROR.
  - IDLE: `hready_out`=1, `hresp`=OKAY.
- A write never changes register contents; the config value is fixed.
- IDLE/BUSY `htrans`, or `hsel`=0, returns the FSM to IDLE with no side effects.

## Timing
- Reset values: state=IDLE, `selreg`=0, `hrdata`=0, `hready_out`=1, `hresp`=OKAY.
- Read latency is zero wait states. The address phase is accepted at edge N. In cycle N..N+1, `selreg`=1 and `hrdata` is valid with `hready_out`=1.
- Back-to-back reads hold `selreg` high continuously.
- A write takes two data-phase cycles (ERR1, ERR2). `hready_in` is low during ERR1, so no address phase is accepted in ERR1.
- An address phase presented during ERR2 with `hready_in`=1 is accepted.
- `sys_reset` asserted mid-transfer forces the reset values immediately, without waiting for a clock edge. After release, the next accepted transfer starts from IDLE.

## Configuration
- Feature macro: `SMC_REGIF_WR_ERR_EN`.
- Defined: writes take the ERR1/ERR2 two-cycle ERROR response.
- Undefined:
  - ERR1 and ERR2 are not built.
  - A write completes in one zero-wait cycle with OKAY and `hrdata`=0.
  - `selreg` stays 0 for writes.

## Test plan
- Reset, then idle bus -> `hready_out`=1, `hresp`=00, `selreg`=0, `hrdata`=0.
- Read at offset 0x00 with `cfg_rdata`=32'hC000_0001 -> next cycle `selreg`=1, `hrdata`=32'hC000_0001, OKAY. The following cycle, with the bus idle, `selreg`=0.
- Three back-to-back reads at 0x00, 0x04, 0x00:
  - `selreg` is 1, 0, 1.
  - `hrdata` is C000_0001, 0, C000_0001.
  - All responses OKAY with no wait states.
- Write at 0x00 with the macro defined -> `hready_out` 0 then 1, `hresp`=ERROR on both cycles. A read presented in ERR2 returns C000_0001 on the next cycle.
- Write at 0x00 with the macro undefined -> one cycle, `hready_out`=1, OKAY, `selreg`=0.
- Assert `sys_reset` during the read data phase -> `selreg` and `hrdata` go to 0 immediately. After release, a read at 0x00 completes normally.
